fetch_ctrl: RTL

- Sequencer for the 9-bit program counter (PC).
- Drives the PC's select/enable pins to load a start address, then steps it by +4 once per completed memory read.
- Performs a req/ack handshake with instruction memory per word.
- Counts fetched words and signals done after a programmed length.
- Sits between the top-level control and the PC/memory pair.

---
 rtl/fetch_ctrl_pkg.sv | 9 +
 rtl/fetch_timer.sv | 29 ++
 rtl/fetch_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding and PC constants for the fetch sequencer
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, REQ, ADV, DONE} fetch_state_t;

   localparam int PC_W    = 9;
   localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - resettable up-counter with terminal flag; fetch_ctrl instantiates it
// only when FETCH_TIMEOUT_EN is defined
module fetch_timer
   import fetch_ctrl_pkg::*;
#(
   parameter int LIMIT = 15,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_term
);

   logic [W-1:0] r_cnt;

   // o_term is high during the LIMIT-th consecutive enabled cycle
   assign o_term = (r_cnt == W'(LIMIT - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_term) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC/instruction-memory fetch sequencer (load, req/ack per word, +4 step)
// Optional REQ watchdog with sticky err: FETCH_TIMEOUT_EN
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int CNT_W = 7
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 15
`endif
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_len,
   input  logic             i_mem_ack,
   output logic             o_pc_sel,
   output logic             o_pc_en,
   output logic             o_mem_req,
   output logic             o_word_valid,
   output logic [CNT_W-1:0] o_word_cnt,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   fetch_state_t     r_state;
   fetch_state_t     w_next;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_word_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_accept;
   logic             w_timeout;

   assign w_accept   = (r_state == IDLE) && i_start;
   assign w_cnt_inc  = r_word_cnt + 1'b1;
   assign o_word_cnt = r_word_cnt;

`ifdef FETCH_TIMEOUT_EN
   logic r_err;

   // Timer runs only while waiting in REQ; any other state restarts it from zero
   fetch_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (r_state != REQ),
      .i_en   ((r_state == REQ) && !i_mem_ack),
      .o_term (w_timeout)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || w_accept) begin
         r_err <= 1'b0;
      end else if ((r_state == REQ) && !i_mem_ack && w_timeout) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign o_err     = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_len      <= '0;
         r_word_cnt <= '0;
      end else if (w_accept) begin
         r_len      <= i_len;
         r_word_cnt <= '0;
      end else if (r_state == ADV) begin
         r_word_cnt <= w_cnt_inc;
      end
   end

   always_comb begin
      w_next       = r_state;
      o_pc_sel     = 1'b0;
      o_pc_en      = 1'b0;
      o_mem_req    = 1'b0;
      o_word_valid = 1'b0;
      o_busy       = 1'b1;
      o_done       = 1'b0;
      case (r_state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_start) begin
               w_next = (i_len == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            o_pc_sel = 1'b1;
            o_pc_en  = 1'b1;
            w_next   = REQ;
         end
         REQ: begin
            o_mem_req = 1'b1;
            // A late ack on the terminal cycle still completes the word
            if (i_mem_ack) begin
               w_next = ADV;
            end else if (w_timeout) begin
               w_next = DONE;
            end
         end
         ADV: begin
            o_pc_en      = 1'b1;
            o_word_valid = 1'b1;
            w_next       = (w_cnt_inc == r_len) ? DONE : REQ;
         end
         DONE: begin
            o_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule
